// File: rtl/turfio_cin_tx_pkg.sv
// Shared definitions for the TURFIO CIN lane transmitter: default words, state encoding,
// and the word-wide PRBS-31 step used by the optional TURFIO_CIN_TX_PRBS_EN training source.
package turfio_cin_tx_pkg;

    localparam logic [31:0] TRAIN_VALUE_DEFAULT = 32'hA55A6996;
    localparam logic [31:0] IDLE_VALUE_DEFAULT  = 32'h00000000;

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_TRAIN = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam logic [31:0] PRBS_SEED  = 32'h00000001;
    localparam int          PRBS_TAP_A = 30;
    localparam int          PRBS_TAP_B = 27;

    // x^31 + x^28 + 1, run 32 bit-steps so every bit of the returned word is new; newest bit in [0]
    function automatic logic [31:0] prbs31Next(input logic [31:0] cur);
        logic [31:0] w;
        logic        b;
        w = cur;
        for (int i = 0; i < 32; i++) begin
            b = w[PRBS_TAP_A] ^ w[PRBS_TAP_B];
            w = {w[30:0], b};
        end
        return w;
    endfunction

endpackage

// File: rtl/turfio_cin_tx_fifo.sv
// Command FIFO for the CIN transmitter: DEPTH x WIDTH, first-word-fall-through head,
// registered ready that already reflects the count after this cycle's push/pop.
module turfio_cin_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             ready_o
);

    localparam int          AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CW         = AW + 1;
    localparam logic [AW:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [AW:0]      r_count;
    logic [AW:0]      w_countNext;
    logic             r_ready;
    logic             w_doPush;
    logic             w_doPop;

    assign empty_o     = (r_count == '0);
    assign full_o      = (r_count == FULL_COUNT);
    assign w_doPush    = push_i && !full_o;
    assign w_doPop     = pop_i && !empty_o;
    assign w_countNext = r_count + CW'(w_doPush) - CW'(w_doPop);
    assign head_o      = r_mem[r_rdPtr];
    assign ready_o     = r_ready;

    // Storage is not reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= dat_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            r_ready <= 1'b0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            r_count <= w_countNext;
            r_ready <= (w_countNext != FULL_COUNT);
        end
    end

endmodule

// File: rtl/turfio_cin_tx.sv
// TURFIO-side CIN lane transmitter: frames 32-bit commands on an 8-clock boundary, MSB nibble first.
// Optional macro TURFIO_CIN_TX_PRBS_EN adds a PRBS-31 training source selected by cmd_valid_i in TRAIN.
module turfio_cin_tx
    import turfio_cin_tx_pkg::*;
#(
    parameter logic [31:0] TRAIN_VALUE = TRAIN_VALUE_DEFAULT,
    parameter logic [31:0] IDLE_VALUE  = IDLE_VALUE_DEFAULT,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic        INV_DOUT    = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        phase_i,
    input  logic        train_i,
    input  logic [31:0] cmd_dat_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    output logic [3:0]  dout_o,
    output logic        word_start_o,
    output logic        phase_err_o,
    output logic [1:0]  state_o
);

    localparam logic [3:0] IDLE_LEVEL = {4{INV_DOUT}};

    state_t      r_state;
    state_t      w_stateNext;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cntNext;
    logic [31:0] r_shift;
    logic [31:0] w_word;
    logic [3:0]  r_dout;
    logic        r_wordStart;
    logic        r_phaseErr;
    logic        w_boundary;
    logic        w_active;
    logic        w_load;
    logic        w_phaseErr;
    logic        w_push;
    logic        w_pop;
    logic [31:0] w_head;
    logic        w_empty;
    logic        w_full;
    logic        w_fifoReady;

    assign w_boundary = (r_cnt == 3'd7);
    assign w_active   = (r_state != ST_WAIT);
    // A phase pulse always realigns; an off-boundary pulse also throws away the word in flight.
    assign w_load     = phase_i || (w_active && w_boundary);
    assign w_phaseErr = w_active && (phase_i != w_boundary);
    assign w_cntNext  = phase_i ? 3'd0 : r_cnt + 3'd1;

`ifdef TURFIO_CIN_TX_PRBS_EN
    logic [31:0] r_prbs;
    logic [31:0] w_prbsNext;
    logic        r_prbsActive;
    logic        w_prbsSel;

    assign w_prbsNext = prbs31Next(r_prbs);
    assign w_prbsSel  = w_load && train_i && cmd_valid_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_prbs       <= PRBS_SEED;
            r_prbsActive <= 1'b0;
        end else if (w_load) begin
            r_prbsActive <= w_prbsSel;
            if (w_prbsSel) begin
                r_prbs <= w_prbsNext;
            end
        end
    end

    assign cmd_ready_o = w_fifoReady && !r_prbsActive;
    assign w_push      = cmd_valid_i && cmd_ready_o && !w_prbsSel && !w_full;
`else
    assign cmd_ready_o = w_fifoReady;
    assign w_push      = cmd_valid_i && cmd_ready_o && !w_full;
`endif

    turfio_cin_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_push),
        .dat_i   (cmd_dat_i),
        .pop_i   (w_pop),
        .head_o  (w_head),
        .empty_o (w_empty),
        .full_o  (w_full),
        .ready_o (w_fifoReady)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_WAIT;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // train_i is only looked at on a load, so the mode always changes on a word boundary.
    always_comb begin
        w_stateNext = r_state;
        w_word      = IDLE_VALUE;
        w_pop       = 1'b0;
        if (w_load) begin
            if (train_i) begin
                w_stateNext = ST_TRAIN;
                w_word      = TRAIN_VALUE;
`ifdef TURFIO_CIN_TX_PRBS_EN
                if (w_prbsSel) begin
                    w_word = w_prbsNext;
                end
`endif
            end else begin
                w_stateNext = ST_RUN;
                if (!w_empty) begin
                    w_word = w_head;
                    w_pop  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt       <= 3'd0;
            r_shift     <= 32'd0;
            r_dout      <= IDLE_LEVEL;
            r_wordStart <= 1'b0;
            r_phaseErr  <= 1'b0;
        end else begin
            r_cnt       <= w_cntNext;
            r_wordStart <= w_load;
            r_phaseErr  <= w_phaseErr;
            if (w_load) begin
                r_dout  <= w_word[31:28] ^ IDLE_LEVEL;
                r_shift <= {w_word[27:0], 4'h0};
            end else if (w_active) begin
                r_dout  <= r_shift[31:28] ^ IDLE_LEVEL;
                r_shift <= {r_shift[27:0], 4'h0};
            end else begin
                r_dout <= IDLE_LEVEL;
            end
        end
    end

    assign dout_o       = r_dout;
    assign word_start_o = r_wordStart;
    assign phase_err_o  = r_phaseErr;
    assign state_o      = r_state;

endmodule

// File: tb/tb_turfio_cin_tx.sv
// Directed bench for turfio_cin_tx: a normal and an INV_DOUT=1 instance share all inputs;
// a table covers training and the first commands, hand-written sequences cover the corner cases.
module tb_turfio_cin_tx;

    typedef struct {
        logic        ph;
        logic        tr;
        logic        v;
        logic [31:0] dat;
        logic [3:0]  expDout;
        logic        expStart;
        logic [1:0]  expState;
        logic        expReady;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstN;
    logic        phase;
    logic        train;
    logic [31:0] cmdDat;
    logic        cmdValid;
    logic        cmdReady, cmdReadyInv;
    logic [3:0]  dout, doutInv;
    logic        wordStart, wordStartInv;
    logic        phaseErr, phaseErrInv;
    logic [1:0]  state, stateInv;

    int          checkCount = 0;
    int          passCount  = 0;
    logic [2:0]  tbCnt;
    vec_t        vecs [40];
    logic [31:0] tblWords [5];
    logic [31:0] aWords [5];
    logic [31:0] expList [7];
    logic [31:0] tmpWord;
    logic [31:0] capQ [$];
    logic        capEn = 1'b0;
    logic [31:0] capAcc;
    int          capN = 0;

    always #5 clk = ~clk;

    turfio_cin_tx #(.FIFO_DEPTH(4), .INV_DOUT(1'b0)) dut (
        .clk_i        (clk),
        .rst_ni       (rstN),
        .phase_i      (phase),
        .train_i      (train),
        .cmd_dat_i    (cmdDat),
        .cmd_valid_i  (cmdValid),
        .cmd_ready_o  (cmdReady),
        .dout_o       (dout),
        .word_start_o (wordStart),
        .phase_err_o  (phaseErr),
        .state_o      (state)
    );

    turfio_cin_tx #(.FIFO_DEPTH(4), .INV_DOUT(1'b1)) dutInv (
        .clk_i        (clk),
        .rst_ni       (rstN),
        .phase_i      (phase),
        .train_i      (train),
        .cmd_dat_i    (cmdDat),
        .cmd_valid_i  (cmdValid),
        .cmd_ready_o  (cmdReadyInv),
        .dout_o       (doutInv),
        .word_start_o (wordStartInv),
        .phase_err_o  (phaseErrInv),
        .state_o      (stateInv)
    );

    // Reassembles whole words from the normal instance; a word cut short by a new start is dropped.
    always @(negedge clk) begin
        if (!capEn) begin
            capN = 0;
        end else begin
            if (wordStart) begin
                capAcc = {28'd0, dout};
                capN   = 1;
            end else if (capN > 0) begin
                capAcc = {capAcc[27:0], dout};
                capN   = capN + 1;
            end
            if (capN == 8) begin
                capQ.push_back(capAcc);
                capN = 0;
            end
        end
    end

    task automatic applyStimulus(input logic ph, input logic tr, input logic v, input logic [31:0] d);
        phase    = ph;
        train    = tr;
        cmdValid = v;
        cmdDat   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic stepRun(input logic tr, input logic v, input logic [31:0] d);
        applyStimulus(tbCnt == 3'd7, tr, v, d);
        tbCnt = tbCnt + 3'd1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

`ifdef TURFIO_CIN_TX_PRBS_EN
    function automatic logic [31:0] prbsModel(input logic [31:0] seed);
        logic        hist [64];
        logic [31:0] r;
        for (int j = 0; j < 32; j++) hist[31 - j] = seed[j];
        for (int n = 32; n < 64; n++) hist[n] = hist[n - 31] ^ hist[n - 28];
        for (int j = 0; j < 32; j++) r[j] = hist[63 - j];
        return r;
    endfunction
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tblWords[0] = 32'hA55A6996;
        tblWords[1] = 32'hA55A6996;
        tblWords[2] = 32'h12345678;
        tblWords[3] = 32'hDEADBEEF;
        tblWords[4] = 32'h00000000;
        for (int w = 0; w < 5; w++) begin
            for (int k = 0; k < 8; k++) begin
                tmpWord                 = tblWords[w] >> (28 - 4 * k);
                vecs[w * 8 + k].ph       = (k == 0);
                vecs[w * 8 + k].tr       = (w < 2);
                vecs[w * 8 + k].v        = (w == 1) && (k == 1 || k == 2);
                vecs[w * 8 + k].dat      = (w == 1 && k == 1) ? 32'h12345678 :
                                           (w == 1 && k == 2) ? 32'hDEADBEEF : 32'h0;
                vecs[w * 8 + k].expDout  = tmpWord[3:0];
                vecs[w * 8 + k].expStart = (k == 0);
                vecs[w * 8 + k].expState = (w < 2) ? 2'd1 : 2'd2;
                vecs[w * 8 + k].expReady = 1'b1;
            end
        end
        aWords[0] = 32'h01234567;
        aWords[1] = 32'h89ABCDEF;
        aWords[2] = 32'hFEDCBA98;
        aWords[3] = 32'h76543210;
        aWords[4] = 32'hC001D00D;

        rstN = 1'b0;
        phase = 1'b0; train = 1'b0; cmdValid = 1'b0; cmdDat = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        $display("[TB] reset values");
        checkOutput("rst_dout", 32'(dout), 32'h0);
        checkOutput("rst_dout_inv", 32'(doutInv), 32'hF);
        checkOutput("rst_start", 32'(wordStart), 32'h0);
        checkOutput("rst_err", 32'(phaseErr), 32'h0);
        checkOutput("rst_state", 32'(state), 32'h0);
        checkOutput("rst_ready", 32'(cmdReady), 32'h0);
        rstN = 1'b1;

        $display("[TB] training, train->run, two commands, idle");
        for (int i = 0; i < 40; i++) begin
            applyStimulus(vecs[i].ph, vecs[i].tr, vecs[i].v, vecs[i].dat);
            checkOutput($sformatf("row%0d_dout", i), 32'(dout), 32'(vecs[i].expDout));
            checkOutput($sformatf("row%0d_dout_inv", i), 32'(doutInv), 32'(vecs[i].expDout ^ 4'hF));
            checkOutput($sformatf("row%0d_start", i), 32'(wordStart), 32'(vecs[i].expStart));
            checkOutput($sformatf("row%0d_err", i), 32'(phaseErr), 32'h0);
            checkOutput($sformatf("row%0d_state", i), 32'(state), 32'(vecs[i].expState));
            checkOutput($sformatf("row%0d_ready", i), 32'(cmdReady), 32'(vecs[i].expReady));
        end
        tbCnt = 3'd7;

        $display("[TB] five pushes into a four-deep FIFO");
        capQ.delete();
        capEn = 1'b1;
        stepRun(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            stepRun(1'b0, 1'b1, aWords[i]);
            checkOutput($sformatf("t3_ready_push%0d", i), 32'(cmdReady), (i == 3) ? 32'h0 : 32'h1);
        end
        for (int i = 0; i < 3; i++) begin
            stepRun(1'b0, 1'b1, aWords[4]);
            checkOutput($sformatf("t3_ready_hold%0d", i), 32'(cmdReady), 32'h0);
        end
        stepRun(1'b0, 1'b1, aWords[4]);
        checkOutput("t3_ready_after_pop", 32'(cmdReady), 32'h1);
        stepRun(1'b0, 1'b1, aWords[4]);
        checkOutput("t3_ready_refull", 32'(cmdReady), 32'h0);
        for (int i = 0; i < 80 && capQ.size() < 7; i++) stepRun(1'b0, 1'b0, 32'h0);
        expList[0] = 32'h0;
        for (int i = 0; i < 5; i++) expList[i + 1] = aWords[i];
        expList[6] = 32'h0;
        checkOutput("t3_word_count", 32'(capQ.size()), 32'd7);
        for (int i = 0; i < 7; i++) begin
            checkOutput($sformatf("t3_word%0d", i), (i < capQ.size()) ? capQ[i] : ~expList[i], expList[i]);
        end

        $display("[TB] early phase pulse discards the word in flight");
        capEn = 1'b0;
        while (tbCnt != 3'd0) stepRun(1'b0, 1'b0, 32'h0);
        stepRun(1'b0, 1'b1, 32'h0BADF00D);
        stepRun(1'b0, 1'b1, 32'h7E57C0DE);
        while (tbCnt != 3'd7) stepRun(1'b0, 1'b0, 32'h0);
        capQ.delete();
        capEn = 1'b1;
        stepRun(1'b0, 1'b0, 32'h0);
        checkOutput("t4_b0_first_nibble", 32'(dout), 32'h0);
        repeat (3) stepRun(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        tbCnt = 3'd0;
        checkOutput("t4_err_pulse", 32'(phaseErr), 32'h1);
        checkOutput("t4_err_start", 32'(wordStart), 32'h1);
        checkOutput("t4_err_dout", 32'(dout), 32'h7);
        checkOutput("t4_err_state", 32'(state), 32'h2);
        stepRun(1'b0, 1'b0, 32'h0);
        checkOutput("t4_err_cleared", 32'(phaseErr), 32'h0);
        checkOutput("t4_start_cleared", 32'(wordStart), 32'h0);
        for (int i = 0; i < 40 && capQ.size() < 2; i++) stepRun(1'b0, 1'b0, 32'h0);
        checkOutput("t4_word_count", 32'(capQ.size()), 32'd2);
        checkOutput("t4_word0", (capQ.size() > 0) ? capQ[0] : 32'h0, 32'h7E57C0DE);
        checkOutput("t4_word1", (capQ.size() > 1) ? capQ[1] : 32'hFFFFFFFF, 32'h0);
        capEn = 1'b0;

        $display("[TB] missing phase pulse at the boundary");
        while (tbCnt != 3'd7) stepRun(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        tbCnt = 3'd0;
        checkOutput("miss_err_pulse", 32'(phaseErr), 32'h1);
        checkOutput("miss_start", 32'(wordStart), 32'h1);
        stepRun(1'b0, 1'b0, 32'h0);
        checkOutput("miss_err_cleared", 32'(phaseErr), 32'h0);

        $display("[TB] reset mid-word flushes the FIFO");
        while (tbCnt != 3'd7) stepRun(1'b0, 1'b0, 32'h0);
        stepRun(1'b1, 1'b0, 32'h0);
        checkOutput("mid_train_state", 32'(state), 32'h1);
        stepRun(1'b1, 1'b1, 32'hC0FFEE11);
        stepRun(1'b1, 1'b0, 32'h0);
        checkOutput("mid_train_dout", 32'(dout), 32'h5);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("mid_rst_dout", 32'(dout), 32'h0);
        checkOutput("mid_rst_dout_inv", 32'(doutInv), 32'hF);
        checkOutput("mid_rst_state", 32'(state), 32'h0);
        checkOutput("mid_rst_ready", 32'(cmdReady), 32'h0);
        checkOutput("mid_rst_start_inv", 32'(wordStartInv), 32'h0);
        checkOutput("mid_rst_err_inv", 32'(phaseErrInv), 32'h0);
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("wait_state", 32'(state), 32'h0);
        checkOutput("wait_dout_inv", 32'(doutInv), 32'hF);
        checkOutput("wait_ready", 32'(cmdReady), 32'h1);
        checkOutput("wait_ready_inv", 32'(cmdReadyInv), 32'h1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        tbCnt = 3'd0;
        checkOutput("flush_state", 32'(state), 32'h2);
        checkOutput("flush_state_inv", 32'(stateInv), 32'h2);
        checkOutput("flush_start", 32'(wordStart), 32'h1);
        checkOutput("flush_dout", 32'(dout), 32'h0);
        checkOutput("flush_dout_inv", 32'(doutInv), 32'hF);

`ifdef TURFIO_CIN_TX_PRBS_EN
        $display("[TB] PRBS training source");
        while (tbCnt != 3'd7) stepRun(1'b0, 1'b0, 32'h0);
        capQ.delete();
        capEn = 1'b1;
        for (int i = 0; i < 9; i++) begin
            stepRun(1'b1, 1'b1, 32'h0);
            checkOutput($sformatf("prbs_ready%0d", i), 32'(cmdReady), 32'h0);
        end
        checkOutput("prbs_state", 32'(state), 32'h1);
        checkOutput("prbs_word0", (capQ.size() > 0) ? capQ[0] : 32'h0, prbsModel(32'h00000001));
        capEn = 1'b0;
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
